muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. Sits in the execute stage directly downstream of the register file: consumes the two register-file read values (rs, rt), runs MULT/MULTU/DIV/DIVU over 33 cycles, and holds the results in HI/LO for MFHI/MFLO. While it is busy, the pipeline control stalls on `busy`.

---
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding HI/LO for the MIPS execute stage.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t      state;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [63:0] acc_step;
  logic [63:0] prod_fix;
  logic [31:0] b;
  logic        neg_a;
  logic [32:0] mul_sum;
  logic        accept;
  logic        signed_op;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
`ifdef MULDIV_DIV_EN
  logic        div_op;
  logic        neg_b;
  logic        div_zero;
  logic [32:0] trial;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    signed_op = ~op[0];
    rs_neg    = signed_op & rs_data[31];
    rt_neg    = signed_op & rt_data[31];
    rs_mag    = rs_neg ? (~rs_data + 32'd1) : rs_data;
    rt_mag    = rt_neg ? (~rt_data + 32'd1) : rt_data;
`ifdef MULDIV_DIV_EN
    accept    = start;
    div_zero  = op[1] & (rt_data == '0);
`else
    accept    = start & ~op[1];
`endif
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? b : 32'd0)};
    acc_step = {mul_sum, acc[31:1]};
    prod_fix = neg_a ? (~acc + 64'd1) : acc;
`ifdef MULDIV_DIV_EN
    trial    = acc[63:31] - {1'b0, b};
    if (div_op) begin
      acc_step = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
    end
    quot_fix = neg_a ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = neg_b ? (~acc[63:32] + 32'd1) : acc[63:32];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      b      <= '0;
      neg_a  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_DIV_EN
      div_op <= 1'b0;
      neg_b  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            count <= '0;
            state <= RUN;
            acc   <= {32'd0, rs_mag};
            b     <= rt_mag;
            neg_a <= rs_neg ^ rt_neg;
`ifdef MULDIV_DIV_EN
            div_op <= op[1];
            neg_b  <= rs_neg;
            // Divide by zero runs on the raw dividend so HI comes out unchanged
            if (div_zero) begin
              acc   <= {32'd0, rs_data};
              b     <= '0;
              neg_a <= 1'b0;
              neg_b <= 1'b0;
            end
`endif
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          acc   <= acc_step;
          count <= count + 5'd1;
          if (count == 5'd31) state <= FINISH;
        end
        FINISH: begin
`ifdef MULDIV_DIV_EN
          if (div_op) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
`else
          hi <= prod_fix[63:32];
          lo <= prod_fix[31:0];
`endif
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, randomized ops against an
// arithmetic reference model, and the busy/move/reset/back-to-back rules.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, mthi, mtlo, busy, done;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata, hi, lo;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] l;
  } vec_t;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference result {HI, LO} straight from the architectural definition
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: return 64'(sa * sb);
      2'd1: return 64'(ua * ub);
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] specials [5];
    specials = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic wait_done(output int bcyc, output bit seen);
    bcyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bcyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = '0; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  task automatic test_directed();
    vec_t tbl[$];
    int   bcyc;
    bit   seen;
    tbl.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tbl.push_back('{2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1});
`ifdef MULDIV_DIV_EN
    tbl.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tbl.push_back('{2'd3, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF});
    tbl.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
`endif
    foreach (tbl[k]) begin
      launch(tbl[k].o, tbl[k].a, tbl[k].b);
      wait_done(bcyc, seen);
      vectors++; if (!seen) begin miscompares++; $display("FAIL dir%0d_done: got no done want done", k); end
      vectors++; if (bcyc != 33) begin miscompares++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", k, bcyc); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL dir%0d_busy_at_done: got %b want 0", k, busy); end
      vectors++; if (hi !== tbl[k].h) begin miscompares++; $display("FAIL dir%0d_hi: got %h want %h", k, hi, tbl[k].h); end
      vectors++; if (lo !== tbl[k].l) begin miscompares++; $display("FAIL dir%0d_lo: got %h want %h", k, lo, tbl[k].l); end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL dir%0d_done_pulse: got %b want 0", k, done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int          bcyc;
    bit          seen;
    for (int n = 0; n < 40; n++) begin
`ifdef MULDIV_DIV_EN
      o = 2'($urandom_range(0, 3));
`else
      o = 2'($urandom_range(0, 1));
`endif
      a = pick_operand();
      b = pick_operand();
      exp = model(o, a, b);
      launch(o, a, b);
      wait_done(bcyc, seen);
      vectors++; if (!seen) begin miscompares++; $display("FAIL rnd%0d_done: got no done want done", n); end
      vectors++; if (hi !== exp[63:32]) begin miscompares++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", n, o, a, b, hi, exp[63:32]); end
      vectors++; if (lo !== exp[31:0]) begin miscompares++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", n, o, a, b, lo, exp[31:0]); end
    end
  endtask

  task automatic test_moves();
    int bcyc;
    bit seen;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_0001;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5A5A_0002;
    vectors++; if (hi !== 32'hA5A5_0001) begin miscompares++; $display("FAIL move_both_hi: got %h want a5a50001", hi); end
    vectors++; if (lo !== 32'hA5A5_0001) begin miscompares++; $display("FAIL move_both_lo: got %h want a5a50001", lo); end
    @(negedge clk);
    mtlo = 1'b0;
    vectors++; if (hi !== 32'hA5A5_0001) begin miscompares++; $display("FAIL move_lo_only_hi: got %h want a5a50001", hi); end
    vectors++; if (lo !== 32'h5A5A_0002) begin miscompares++; $display("FAIL move_lo_only_lo: got %h want 5a5a0002", lo); end
    // start together with a move: the move is dropped
    start = 1'b1; op = 2'd1; rs_data = 32'd3; rt_data = 32'd4; mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_wins_busy: got %b want 1", busy); end
    vectors++; if (hi !== 32'hA5A5_0001) begin miscompares++; $display("FAIL start_wins_hi: got %h want a5a50001", hi); end
    wait_done(bcyc, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL start_wins_done: got no done want done"); end
    vectors++; if ({hi, lo} !== 64'd12) begin miscompares++; $display("FAIL start_wins_result: got %h want 12", {hi, lo}); end
  endtask

  task automatic test_busy_rules();
    int bcyc;
    bit seen;
    launch(2'd1, 32'd7, 32'd6);
    repeat (4) @(negedge clk);
    mtlo = 1'b1; mthi = 1'b1; wdata = 32'h0000_1234;
    start = 1'b1; op = 2'd1; rs_data = 32'd99; rt_data = 32'd99;
    @(negedge clk);
    mtlo = 1'b0; mthi = 1'b0; start = 1'b0;
    wait_done(bcyc, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL busy_move_done: got no done want done"); end
    vectors++; if (lo !== 32'd42) begin miscompares++; $display("FAIL busy_move_lo: got %h want 0000002a", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL busy_move_hi: got %h want 0", hi); end
  endtask

  task automatic test_back_to_back();
    int bcyc;
    bit seen;
    launch(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done(bcyc, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_first_done: got no done want done"); end
    start = 1'b1; op = 2'd1; rs_data = 32'd7; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accepted: got busy=%b want 1", busy); end
    wait_done(bcyc, seen);
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_second_done: got no done want done"); end
    vectors++; if (bcyc != 33) begin miscompares++; $display("FAIL b2b_busy_cycles: got %0d want 33", bcyc); end
    vectors++; if ({hi, lo} !== 64'd63) begin miscompares++; $display("FAIL b2b_result: got %h want 63", {hi, lo}); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b want 0", done); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL midreset_hi: got %h want 0", hi); end
    vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL midreset_lo: got %h want 0", lo); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL midreset_late_activity: got busy/done want none"); end
  endtask

`ifndef MULDIV_DIV_EN
  task automatic test_div_disabled();
    bit seen;
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    launch(2'd2, 32'd100, 32'd7);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL nodiv_activity: got busy/done want none"); end
    vectors++; if (hi !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL nodiv_hi: got %h want 0badf00d", hi); end
    vectors++; if (lo !== 32'h0BAD_F00D) begin miscompares++; $display("FAIL nodiv_lo: got %h want 0badf00d", lo); end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_moves();
    test_busy_rules();
    test_back_to_back();
    test_reset_mid();
`ifndef MULDIV_DIV_EN
    test_div_disabled();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
